// File: rtl/i2c_init.sv
// Write-only I2C sequencer: after reset, sends a fixed ROM as one write transaction to the codec.
// Optional I2C_INIT_DONE_EN adds a registered 'done' output that is high once the sequence has finished.
module i2c_init #(
  parameter int STARTUP_DELAY = 16,
  parameter int NUM_BYTES     = 23
) (
  input  logic clk,
  input  logic rst,
  output logic scl,
`ifdef I2C_INIT_DONE_EN
  output logic sda_out,
  output logic done
`else
  output logic sda_out
`endif
);
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int DW = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY + 1) : 1;
  localparam logic [DW-1:0] DLY_LOAD = DW'(STARTUP_DELAY - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {S_DELAY, S_START, S_BYTE, S_STOP, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dly, dly_nxt;
  logic [1:0]      qtr, qtr_nxt;
  logic [3:0]      bit_cnt, bit_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic            scl_nxt, sda_nxt;
  logic [7:0]      cur_byte;
  logic            tx_bit;

  function automatic logic [7:0] rom(input logic [IW-1:0] i);
    case (int'(i))
      0:  rom = 8'h20;  1:  rom = 8'h00;  2:  rom = 8'h36;  3:  rom = 8'hAE;
      4:  rom = 8'h1C;  5:  rom = 8'h00;  6:  rom = 8'h22;  7:  rom = 8'h22;
      8:  rom = 8'h00;  9:  rom = 8'h00;  10: rom = 8'h22;  11: rom = 8'h22;
      12: rom = 8'h00;  13: rom = 8'h00;  14: rom = 8'h55;  15: rom = 8'h07;
      16: rom = 8'h0E;  17: rom = 8'h18;  18: rom = 8'h18;  19: rom = 8'h00;
      20: rom = 8'h00;  21: rom = 8'h04;  22: rom = 8'h0A;
      default: rom = 8'h00;
    endcase
  endfunction

  // Bit slot 8 is the ACK slot: SDA is released and the reply is ignored.
  assign cur_byte = rom(idx);
  assign tx_bit   = (bit_cnt == 4'd8) ? 1'b1 : cur_byte[3'(4'd7 - bit_cnt)];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_DELAY;
      dly     <= DLY_LOAD;
      qtr     <= 2'd0;
      bit_cnt <= 4'd0;
      idx     <= '0;
      scl     <= 1'b1;
      sda_out <= 1'b1;
`ifdef I2C_INIT_DONE_EN
      done    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      dly     <= dly_nxt;
      qtr     <= qtr_nxt;
      bit_cnt <= bit_nxt;
      idx     <= idx_nxt;
      scl     <= scl_nxt;
      sda_out <= sda_nxt;
`ifdef I2C_INIT_DONE_EN
      done    <= (state == S_DONE);
`endif
    end
  end

  // The registers describe the cycle about to be emitted; outputs register that cycle's line values.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    qtr_nxt   = qtr;
    bit_nxt   = bit_cnt;
    idx_nxt   = idx;
    scl_nxt   = 1'b1;
    sda_nxt   = 1'b1;
    case (state)
      S_DELAY: begin
        if (dly == '0) begin
          state_nxt = S_START;
          qtr_nxt   = 2'd0;
        end else begin
          dly_nxt = dly - DW'(1);
        end
      end
      S_START: begin
        sda_nxt = 1'b0;
        if (qtr == 2'd0) begin
          qtr_nxt = 2'd1;
        end else begin
          scl_nxt   = 1'b0;
          state_nxt = S_BYTE;
          qtr_nxt   = 2'd0;
          bit_nxt   = 4'd0;
          idx_nxt   = '0;
        end
      end
      S_BYTE: begin
        scl_nxt = (qtr == 2'd1) || (qtr == 2'd2);
        sda_nxt = tx_bit;
        qtr_nxt = qtr + 2'd1;
        if (qtr == 2'd3) begin
          if (bit_cnt == 4'd8) begin
            bit_nxt = 4'd0;
            if (idx == LAST_IDX) begin
              state_nxt = S_STOP;
              qtr_nxt   = 2'd0;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end
      end
      S_STOP: begin
        scl_nxt = (qtr != 2'd0);
        sda_nxt = (qtr == 2'd2);
        qtr_nxt = qtr + 2'd1;
        if (qtr == 2'd2) begin
          state_nxt = S_DONE;
          qtr_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = S_DONE;
      end
    endcase
  end
endmodule

// File: tb/tb_i2c_init.sv
// Bench for i2c_init: expected line waveform built from the transaction rules, plus an I2C slave decoder.
module tb_i2c_init;
  localparam int SD    = 16;
  localparam int NB    = 23;
  localparam int TOTAL = SD + 2 + 36 * NB + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl, sda_out;
`ifdef I2C_INIT_DONE_EN
  logic done;
`endif

  i2c_init #(.STARTUP_DELAY(SD), .NUM_BYTES(NB)) dut (
    .clk(clk),
    .rst(rst),
    .scl(scl),
`ifdef I2C_INIT_DONE_EN
    .sda_out(sda_out),
    .done(done)
`else
    .sda_out(sda_out)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] rom [NB] = '{8'h20, 8'h00, 8'h36, 8'hAE, 8'h1C, 8'h00, 8'h22, 8'h22,
                           8'h00, 8'h00, 8'h22, 8'h22, 8'h00, 8'h00, 8'h55, 8'h07,
                           8'h0E, 8'h18, 8'h18, 8'h00, 8'h00, 8'h04, 8'h0A};

  logic q_scl[$];
  logic q_sda[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  logic prev_scl, prev_sda;
  int   starts, stops, start_cyc, stop_cyc;
  logic bits[$];

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
  endtask

  task automatic push(input logic s, input logic d);
    q_scl.push_back(s);
    q_sda.push_back(d);
  endtask

  // Waveform per cycle after reset release, straight from the transaction description.
  task automatic build_model();
    logic v;
    repeat (SD) push(1'b1, 1'b1);
    push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    for (int i = 0; i < NB; i++) begin
      for (int b = 0; b < 9; b++) begin
        v = (b < 8) ? rom[i][7-b] : 1'b1;
        push(1'b0, v); push(1'b1, v); push(1'b1, v); push(1'b0, v);
      end
    end
    push(1'b0, 1'b0);
    push(1'b1, 1'b0);
    push(1'b1, 1'b1);
  endtask

  task automatic clear_decoder();
    bits.delete();
    starts = 0; stops = 0; start_cyc = -1; stop_cyc = -1;
    prev_scl = 1'b1; prev_sda = 1'b1;
  endtask

  task automatic tick(input logic r);
    logic es, ed;
    @(negedge clk);
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      cyc = 0;
      clear_decoder();
      chk("rst scl", int'(scl), 1);
      chk("rst sda", int'(sda_out), 1);
`ifdef I2C_INIT_DONE_EN
      chk("rst done", int'(done), 0);
`endif
    end else begin
      cyc++;
      es = (cyc <= TOTAL) ? q_scl[cyc-1] : 1'b1;
      ed = (cyc <= TOTAL) ? q_sda[cyc-1] : 1'b1;
      chk($sformatf("scl c%0d", cyc), int'(scl), int'(es));
      chk($sformatf("sda c%0d", cyc), int'(sda_out), int'(ed));
`ifdef I2C_INIT_DONE_EN
      chk($sformatf("done c%0d", cyc), int'(done), (cyc > TOTAL) ? 1 : 0);
`endif
      if (prev_scl && scl && (prev_sda != sda_out)) begin
        if (!sda_out) begin starts++; start_cyc = cyc; end
        else begin stops++; stop_cyc = cyc; end
      end
      if (!prev_scl && scl && starts > 0 && stops == 0) bits.push_back(sda_out);
      prev_scl = scl;
      prev_sda = sda_out;
    end
  endtask

  task automatic check_txn(input string p);
    logic [7:0] val;
    int nby;
    chk({p, " starts"}, starts, 1);
    chk({p, " stops"}, stops, 1);
    chk({p, " start cyc"}, start_cyc, SD + 1);
    chk({p, " stop cyc"}, stop_cyc, TOTAL);
    chk({p, " nbits"}, bits.size(), NB * 9 + 1);
    nby = bits.size() / 9;
    chk({p, " nbytes"}, nby, NB);
    for (int i = 0; i < nby && i < NB; i++) begin
      val = '0;
      for (int b = 0; b < 8; b++) val = {val[6:0], bits[i*9+b]};
      chk($sformatf("%s byte%0d", p, i), int'(val), int'(rom[i]));
      chk($sformatf("%s ack%0d", p, i), int'(bits[i*9+8]), 1);
    end
  endtask

  initial begin
    int off, at, len;
    build_model();
    clear_decoder();

    repeat (3) tick(1'b1);
    repeat (TOTAL + 1000) tick(1'b0);
    check_txn("full");

    tick(1'b1);
    off = $urandom_range(0, 35);
    repeat (SD + 2 + 36 * 5 + off) tick(1'b0);
    tick(1'b1);
    repeat (TOTAL + 20) tick(1'b0);
    check_txn("abort b5");

    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 3);
      at  = $urandom_range(1, TOTAL + 50);
      repeat (len) tick(1'b1);
      repeat (at) tick(1'b0);
    end
    tick(1'b1);
    repeat (TOTAL + 20) tick(1'b0);
    check_txn("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
